// File: rtl/plane_loader.sv
// Frame loader for the plane controller bus: command preamble, then OUT_NUM strobed data writes.
// Define PLANE_LOADER_CLEAR_EN to issue a clear-memory command ahead of the preamble.
module plane_loader #(
  parameter int OUT_NUM       = 64,
  parameter int D_WIDTH       = 8,
  parameter int STROBE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [D_WIDTH-1:0] dataOut,
  output logic               dataEn,
  output logic               rs,
  output logic               busy,
  output logic               frame_done
);

  localparam int CW = $clog2(OUT_NUM);
  localparam int PW = $clog2(2 * STROBE_CYCLES);

  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_NUM - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * STROBE_CYCLES - 1);
  localparam logic [PW-1:0] PH_LOW   = PW'(STROBE_CYCLES);

  localparam logic [D_WIDTH-1:0] OP_INC  = D_WIDTH'(8'h06);
  localparam logic [D_WIDTH-1:0] OP_ZERO = D_WIDTH'(8'h02);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD_INC   = 3'd1;
  localparam logic [2:0] CMD_ZERO  = 3'd2;
  localparam logic [2:0] WAIT_DATA = 3'd3;
  localparam logic [2:0] WRITE     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
`ifdef PLANE_LOADER_CLEAR_EN
  localparam logic [2:0] CMD_CLEAR = 3'd6;
  localparam logic [D_WIDTH-1:0] OP_CLEAR = D_WIDTH'(8'h01);
`endif

  logic [2:0]    state;
  logic [PW-1:0] ph;
  logic [CW-1:0] cnt;
  logic          in_txn;
  logic          txn_end;

  always_comb begin
    in_txn = 1'b0;
    case (state)
      CMD_INC, CMD_ZERO, WRITE: in_txn = 1'b1;
`ifdef PLANE_LOADER_CLEAR_EN
      CMD_CLEAR:                in_txn = 1'b1;
`endif
      default:                  in_txn = 1'b0;
    endcase
  end

  // Strobe is decoded from the phase counter so reset drops it on the same edge.
  assign txn_end    = in_txn && (ph == PH_LAST);
  assign dataEn     = in_txn && (ph < PH_LOW);
  assign in_ready   = (state == WAIT_DATA);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ph      <= '0;
      cnt     <= '0;
      rs      <= 1'b0;
      dataOut <= '0;
    end else begin
      ph <= (txn_end || !in_txn) ? '0 : ph + 1'b1;
      case (state)
        IDLE: if (start) begin
          rs <= 1'b1;
`ifdef PLANE_LOADER_CLEAR_EN
          state   <= CMD_CLEAR;
          dataOut <= OP_CLEAR;
`else
          state   <= CMD_INC;
          dataOut <= OP_INC;
`endif
        end
`ifdef PLANE_LOADER_CLEAR_EN
        CMD_CLEAR: if (txn_end) begin
          state   <= CMD_INC;
          dataOut <= OP_INC;
        end
`endif
        CMD_INC: if (txn_end) begin
          state   <= CMD_ZERO;
          dataOut <= OP_ZERO;
        end
        CMD_ZERO: if (txn_end) state <= WAIT_DATA;
        // dataOut doubles as the holding register for the accepted byte
        WAIT_DATA: if (in_valid) begin
          state   <= WRITE;
          rs      <= 1'b0;
          dataOut <= in_data;
        end
        WRITE: if (txn_end) begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= WAIT_DATA;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plane_loader.sv
// Bench for plane_loader: a per-cycle trace model built from the bus rules, plus literal frame checks.
module tb_plane_loader;
  localparam int S = 2;
  localparam int N = 4;
`ifdef PLANE_LOADER_CLEAR_EN
  localparam int CLR = 2 * S;
`else
  localparam int CLR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_ready, dataEn, rs, busy, frame_done;
  logic [7:0] in_data, dataOut;

  always #5 clk = ~clk;

  plane_loader #(.OUT_NUM(N), .D_WIDTH(8), .STROBE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .dataOut(dataOut), .dataEn(dataEn), .rs(rs), .busy(busy),
    .frame_done(frame_done)
  );

  // Frame description, written by the main process only.
  logic [7:0] fb [N];
  int         fg [N];
  int         frame_req = 0;
  int         exp_len = 0;
  logic [8:0] exp_lat [$];

  // ---------------- stream source ----------------
  initial begin : source
    int src_seen = 0;
    int idx = N;
    int gap = 0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (frame_req != src_seen) begin
        src_seen = frame_req;
        idx = 0;
        gap = fg[0];
      end
      if (reset !== 1'b1) idx = N;
      if (idx < N) begin
        if (gap > 0) begin
          in_valid = 1'b0;
          if (in_ready) gap--;
        end else begin
          in_valid = 1'b1;
          in_data  = fb[idx];
          if (in_ready) begin
            idx++;
            if (idx < N) gap = fg[idx];
          end
        end
      end else begin
        // junk offered whenever no frame byte is pending; it must never be taken
        in_valid = 1'b1;
        in_data  = 8'hEE;
      end
    end
  end

  // ---------------- model and compare ----------------
  typedef struct packed {
    logic       busy;
    logic       en;
    logic       rdy;
    logic       fd;
    logic       bus;
    logic       r;
    logic [7:0] d;
  } exp_t;

  exp_t       expq [$];
  logic [8:0] lat [$];
  int         checks = 0, errors = 0, ncyc = 0;
  int         seen = 0, fstart = 0, fd_cnt = 0, len = 0, falls = 0;
  logic       active = 1'b0, prev_en = 1'b0, prev_busy = 1'b0;
  logic       last_r = 1'b0;
  logic [7:0] last_d = 8'h00;
  logic       rst_s;

  always @(posedge clk) rst_s <= reset;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, ncyc, act, exp);
    end
  endfunction

  function automatic void push(input logic b, input logic en, input logic rdy, input logic fd,
                               input logic bus, input logic r, input logic [7:0] d);
    exp_t e;
    e.busy = b; e.en = en; e.rdy = rdy; e.fd = fd; e.bus = bus; e.r = r; e.d = d;
    expq.push_back(e);
  endfunction

  // One bus transaction: S cycles strobe high, S low, rs/data held throughout.
  function automatic void txn(input logic r, input logic [7:0] d);
    for (int i = 0; i < 2 * S; i++) push(1'b1, (i < S), 1'b0, 1'b0, 1'b1, r, d);
    last_r = r;
    last_d = d;
  endfunction

  function automatic void build();
    expq.delete();
`ifdef PLANE_LOADER_CLEAR_EN
    txn(1'b1, 8'h01);
`endif
    txn(1'b1, 8'h06);
    txn(1'b1, 8'h02);
    for (int k = 0; k < N; k++) begin
      for (int w = 0; w < fg[k]; w++) push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      push(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      txn(1'b0, fb[k]);
    end
    push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endfunction

  function automatic void end_checks();
    chk("frame_len", 32'(len), 32'(exp_len));
    chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
    chk("busy_falls", 32'(falls), 32'd1);
    chk("latch_count", 32'(lat.size()), 32'(exp_lat.size()));
    for (int i = 0; i < exp_lat.size(); i++)
      chk($sformatf("latch_%0d", i), (i < lat.size()) ? 32'(lat[i]) : 32'hFFFF_FFFF, 32'(exp_lat[i]));
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    ncyc++;
    if (rst_s === 1'b0) begin
      expq.delete();
      active = 1'b0;
      last_r = 1'b0;
      last_d = 8'h00;
      chk("rst_dataOut", 32'(dataOut), 32'd0);
      chk("rst_dataEn", 32'(dataEn), 32'd0);
      chk("rst_rs", 32'(rs), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
    end else if (rst_s === 1'b1) begin
      if (frame_req != seen) begin
        seen = frame_req;
        build();
        active = 1'b1;
        fstart = ncyc;
        fd_cnt = 0;
        falls  = 0;
        len    = 0;
        lat.delete();
        chk("model_len", 32'(expq.size()), 32'(exp_len));
      end
      if (active && prev_busy && !busy) falls++;
      if (active && prev_en && !dataEn) lat.push_back({rs, dataOut});
      if (active && frame_done) begin
        fd_cnt++;
        if (fd_cnt == 1) len = ncyc - fstart + 1;
      end
      if (expq.size() > 0) begin
        e = expq.pop_front();
      end else begin
        e.busy = 1'b0; e.en = 1'b0; e.rdy = 1'b0; e.fd = 1'b0; e.bus = 1'b1;
        e.r = last_r; e.d = last_d;
        if (active) begin
          end_checks();
          active = 1'b0;
        end
      end
      chk("busy", 32'(busy), 32'(e.busy));
      chk("dataEn", 32'(dataEn), 32'(e.en));
      chk("in_ready", 32'(in_ready), 32'(e.rdy));
      chk("frame_done", 32'(frame_done), 32'(e.fd));
      if (e.bus) begin
        chk("rs", 32'(rs), 32'(e.r));
        chk("dataOut", 32'(dataOut), 32'(e.d));
      end
    end
    prev_en   = dataEn;
    prev_busy = busy;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [7:0] b0, b1, b2, b3, input int g1, input int l);
    fb = '{b0, b1, b2, b3};
    fg = '{0, g1, 0, 0};
    exp_len = l;
    exp_lat.delete();
`ifdef PLANE_LOADER_CLEAR_EN
    exp_lat.push_back(9'h101);
`endif
    exp_lat.push_back(9'h106);
    exp_lat.push_back(9'h102);
    exp_lat.push_back({1'b0, b0});
    exp_lat.push_back({1'b0, b1});
    exp_lat.push_back({1'b0, b2});
    exp_lat.push_back({1'b0, b3});
  endtask

  task automatic go();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    frame_req++;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    cyc(6);
    reset = 1'b1;
    start = 1'b0;
    cyc(3);

    // always-valid stream: 1 + 8 + 4*5 cycles to frame_done
    setup(8'h0A, 8'h0B, 8'h0C, 8'h0D, 0, 29 + CLR);
    go();
    cyc(29 + CLR + 3);

    // ten ready-but-invalid cycles ahead of the second byte
    setup(8'h11, 8'h22, 8'h33, 8'h44, 10, 39 + CLR);
    go();
    cyc(39 + CLR + 3);

    // start re-pulsed mid-frame and again during the frame_done cycle
    setup(8'h5A, 8'hA5, 8'hFF, 8'h00, 0, 29 + CLR);
    go();
    cyc(10);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(29 + CLR - 12);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);

    // reset during the first strobe-high cycle, then a clean frame
    setup(8'h01, 8'h02, 8'h03, 8'h04, 0, 29 + CLR);
    go();
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    go();
    cyc(29 + CLR + 3);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
